// File: rtl/clk_meter_pkg.sv
// Shared types and helpers for clk_period_meter: state encoding, default
// counter width and the absolute-difference function used by lock/duty checks.
package clk_meter_pkg;

    localparam int CNT_W_DEFAULT = 28;
    localparam int ABS_W         = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_e;

    // Operands are zero-extended by the caller, so this matches the narrower
    // unsigned difference exactly.
    function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] a,
                                                  input logic [ABS_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// SYNC_STAGES-deep synchronizer for an asynchronous input, plus a delayed copy
// used to flag the first synchronized high cycle as a rising edge.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic sig_in,
    output logic s,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sig_in};
        s_d_d  = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses <= only, so every flop samples the
    // pre-edge value of its neighbours and the chain shifts by one stage.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            s_d_q  <= s_d_d;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock in clk_in cycles, with lock and
// sticky timeout. Optional duty_ok output under `CLK_PERIOD_METER_DUTY_EN.
module clk_period_meter
    import clk_meter_pkg::*;
#(
    parameter int               CNT_W       = CNT_W_DEFAULT,
    parameter int               SYNC_STAGES = 2,
    parameter logic [CNT_W-1:0] TIMEOUT_CYC = CNT_W'(20_000_000),
    parameter int               LOCK_COUNT  = 4,
    parameter int               TOL         = 1
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             timeout
`ifdef CLK_PERIOD_METER_DUTY_EN
    ,
    output logic             duty_ok
`endif
);

    localparam int               LC_W     = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_COUNT);
    localparam logic [ABS_W-1:0] TOL_W    = ABS_W'(TOL);

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [LC_W-1:0]  lock_cnt_q, lock_cnt_d;
    logic             mv_q, mv_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;
    logic             have_ref_q, have_ref_d;

    logic             s, rise;
    logic [CNT_W-1:0] new_period;
    logic             period_match;
    logic             at_limit;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in(clk_in),
        .rst   (rst),
        .sig_in(sig_in),
        .s     (s),
        .rise  (rise)
    );

    // cnt is cleared on the edge cycle, so the edge-to-edge distance is cnt+1.
    assign new_period   = cnt_q + CNT_W'(1);
    assign period_match = abs_diff(ABS_W'(new_period), ABS_W'(period_q)) <= TOL_W;
    assign at_limit     = (cnt_q == TIMEOUT_CYC - CNT_W'(1));

`ifdef CLK_PERIOD_METER_DUTY_EN
    localparam logic [ABS_W-1:0] TOL2_W = ABS_W'(2 * TOL);
    logic duty_q, duty_d;
    logic duty_match;
    assign duty_match = abs_diff(ABS_W'(hcnt_q) << 1, ABS_W'(new_period)) <= TOL2_W;
`endif

    // NOTE: every variable gets its hold/default value first, so no branch
    // can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hcnt_d     = hcnt_q;
        period_d   = period_q;
        high_d     = high_q;
        lock_cnt_d = lock_cnt_q;
        mv_d       = 1'b0;
        locked_d   = locked_q;
        timeout_d  = timeout_q;
        have_ref_d = have_ref_q;
`ifdef CLK_PERIOD_METER_DUTY_EN
        duty_d     = duty_q;
`endif

        if (!enable) begin
            // Disable outranks an edge arriving in the same cycle.
            state_d    = IDLE;
            cnt_d      = '0;
            hcnt_d     = '0;
            lock_cnt_d = '0;
            locked_d   = 1'b0;
            timeout_d  = 1'b0;
            have_ref_d = 1'b0;
`ifdef CLK_PERIOD_METER_DUTY_EN
            duty_d     = 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = '0;
                        hcnt_d  = CNT_W'(1);
                        state_d = MEASURE;
                    end else if (at_limit) begin
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        period_d   = new_period;
                        high_d     = hcnt_q;
                        mv_d       = 1'b1;
                        timeout_d  = 1'b0;
                        cnt_d      = '0;
                        hcnt_d     = CNT_W'(1);
                        have_ref_d = 1'b1;
`ifdef CLK_PERIOD_METER_DUTY_EN
                        duty_d     = duty_match;
`endif
                        // The first period after ARM only seeds the comparison.
                        if (have_ref_q) begin
                            if (period_match) begin
                                if (lock_cnt_q != LOCK_MAX) begin
                                    lock_cnt_d = lock_cnt_q + LC_W'(1);
                                end
                                locked_d = (lock_cnt_d == LOCK_MAX);
                            end else begin
                                lock_cnt_d = '0;
                                locked_d   = 1'b0;
                            end
                        end
                    end else if (at_limit) begin
                        timeout_d  = 1'b1;
                        locked_d   = 1'b0;
                        lock_cnt_d = '0;
                        cnt_d      = '0;
                        hcnt_d     = '0;
                        have_ref_d = 1'b0;
                        state_d    = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (s) begin
                            hcnt_d = hcnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hcnt_q     <= '0;
            period_q   <= '0;
            high_q     <= '0;
            lock_cnt_q <= '0;
            mv_q       <= 1'b0;
            locked_q   <= 1'b0;
            timeout_q  <= 1'b0;
            have_ref_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hcnt_q     <= hcnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            lock_cnt_q <= lock_cnt_d;
            mv_q       <= mv_d;
            locked_q   <= locked_d;
            timeout_q  <= timeout_d;
            have_ref_q <= have_ref_d;
        end
    end

`ifdef CLK_PERIOD_METER_DUTY_EN
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            duty_q <= 1'b0;
        end else begin
            duty_q <= duty_d;
        end
    end

    assign duty_ok = duty_q;
`endif

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter: two instances (TOL=1 and TOL=2) share
// stimulus; define CLK_PERIOD_METER_DUTY_EN to also exercise duty_ok.
module tb_clk_period_meter;
    import clk_meter_pkg::*;

    localparam int CNT_W = 28;

    logic             clk_in = 1'b0;
    logic             rst    = 1'b1;
    logic             enable = 1'b0;
    logic             sig_in = 1'b0;

    logic [CNT_W-1:0] period_a, high_a, period_b, high_b;
    logic             meas_valid_a, locked_a, timeout_a;
    logic             meas_valid_b, locked_b, timeout_b;
`ifdef CLK_PERIOD_METER_DUTY_EN
    logic             duty_ok_a, duty_ok_b;
`endif

    int checks = 0;
    int errors = 0;
    int tick = 0;
    int last_mv_tick = -1;
    int to_tick = -1;
    int mv_count = 0;
    logic timeout_prev = 1'b0;

    int unsigned qa_period[$];
    int unsigned qa_high[$];
    int unsigned qa_locked[$];
    int unsigned qa_timeout[$];
    int unsigned qa_duty[$];
    int unsigned qb_locked[$];

    always #5 clk_in = ~clk_in;

    clk_period_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYC(28'd100), .LOCK_COUNT(4), .TOL(1)
    ) dut_a (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period_a),
        .high_time (high_a),
        .meas_valid(meas_valid_a),
        .locked    (locked_a),
        .timeout   (timeout_a)
`ifdef CLK_PERIOD_METER_DUTY_EN
        ,
        .duty_ok   (duty_ok_a)
`endif
    );

    clk_period_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYC(28'd100), .LOCK_COUNT(4), .TOL(2)
    ) dut_b (
        .clk_in    (clk_in),
        .rst       (rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period_b),
        .high_time (high_b),
        .meas_valid(meas_valid_b),
        .locked    (locked_b),
        .timeout   (timeout_b)
`ifdef CLK_PERIOD_METER_DUTY_EN
        ,
        .duty_ok   (duty_ok_b)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned at(input int unsigned q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
    endfunction

    // Drive sig_in, advance one clk_in edge, sample 1 ns later and log events.
    task automatic step(input logic v);
        sig_in = v;
        @(posedge clk_in);
        #1;
        tick++;
        if (meas_valid_a) begin
            mv_count++;
            last_mv_tick = tick;
            qa_period.push_back(int'(period_a));
            qa_high.push_back(int'(high_a));
            qa_locked.push_back({31'd0, locked_a});
            qa_timeout.push_back({31'd0, timeout_a});
`ifdef CLK_PERIOD_METER_DUTY_EN
            qa_duty.push_back({31'd0, duty_ok_a});
`endif
        end
        if (meas_valid_b) begin
            qb_locked.push_back({31'd0, locked_b});
        end
        if (timeout_a && !timeout_prev) begin
            to_tick = tick;
        end
        timeout_prev = timeout_a;
    endtask

    task automatic run_period(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    task automatic clear_logs();
        qa_period.delete();
        qa_high.delete();
        qa_locked.delete();
        qa_timeout.delete();
        qa_duty.delete();
        qb_locked.delete();
        mv_count = 0;
    endtask

    initial begin
        int lock_or;
        int mv_before;

        // Reset values, before any clock edge.
        #3;
        check("rst_period", period_a, 0);
        check("rst_high", high_a, 0);
        check("rst_mv", meas_valid_a, 0);
        check("rst_locked", locked_a, 0);
        check("rst_timeout", timeout_a, 0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);

        // Divide-by-10 clock: first period arms, lock on the fifth meas_valid.
        run_period(5, 5);
        check("arm_no_mv", mv_count, 0);
        for (int p = 0; p < 6; p++) run_period(5, 5);
        check("div10_mv_count", mv_count, 6);
        check("div10_period", at(qa_period, 0), 10);
        check("div10_high", at(qa_high, 0), 5);
        check("div10_unlocked_4th", at(qa_locked, 3), 0);
        check("div10_locked_5th", at(qa_locked, 4), 1);
        check("div10_locked_6th", at(qa_locked, 5), 1);
`ifdef CLK_PERIOD_METER_DUTY_EN
        check("duty_ok_50pct", at(qa_duty, 0), 1);
`endif

        // Asynchronous reset mid-MEASURE, observed without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        check("arst_period", period_a, 0);
        check("arst_high", high_a, 0);
        check("arst_locked", locked_a, 0);
        check("arst_mv", meas_valid_a, 0);
        step(1'b0);
        step(1'b0);
        rst = 1'b0;
        clear_logs();
        for (int i = 0; i < 3; i++) step(1'b0);
        run_period(5, 5);
        check("arst_first_edge_no_mv", mv_count, 0);
        run_period(5, 5);
        check("arst_second_edge_mv", mv_count, 1);
        check("arst_period_again", at(qa_period, 0), 10);

        // Lock again, then stop sig_in and time the timeout.
        for (int p = 0; p < 4; p++) run_period(5, 5);
        check("relock", locked_a, 1);
        to_tick = -1;
        for (int i = 0; i < 300 && to_tick < 0; i++) step(1'b0);
        check("timeout_delay", to_tick - last_mv_tick, 100);
        check("timeout_flag", timeout_a, 1);
        check("timeout_unlock", locked_a, 0);
        check("timeout_period_hold", period_a, 10);

        // Restart: first edge only re-arms, second clears timeout with meas_valid.
        mv_before = mv_count;
        run_period(5, 5);
        check("restart_arm_no_mv", mv_count, mv_before);
        check("restart_timeout_held", timeout_a, 1);
        run_period(5, 5);
        check("restart_mv", mv_count, mv_before + 1);
        check("restart_timeout_clr_at_mv", at(qa_timeout, qa_timeout.size() - 1), 0);
        check("restart_timeout_clr", timeout_a, 0);

        // Alternating 10/12 periods: TOL=1 never locks, TOL=2 locks on 5th.
        enable = 1'b0;
        step(1'b0);
        step(1'b0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        clear_logs();
        for (int p = 0; p < 3; p++) begin
            run_period(5, 5);
            run_period(5, 7);
        end
        check("alt_mv_count", mv_count, 5);
        check("alt_period_2nd", at(qa_period, 1), 12);
        lock_or = 0;
        foreach (qa_locked[i]) lock_or |= int'(qa_locked[i]);
        check("alt_tol1_never_locked", lock_or, 0);
        check("alt_tol2_4th_unlocked", at(qb_locked, 3), 0);
        check("alt_tol2_5th_locked", at(qb_locked, 4), 1);

        // Drop enable in the very cycle the edge detector fires.
        mv_before = mv_count;
        step(1'b1);
        step(1'b1);
        check("drop_rise_aligned", dut_a.u_sync.rise, 1);
        enable = 1'b0;
        step(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1);
        check("drop_no_mv", mv_count, mv_before);
        check("drop_state_idle", dut_a.state_q, IDLE);
        check("drop_locked_a", locked_a, 0);
        check("drop_locked_b", locked_b, 0);
        check("drop_timeout", timeout_a, 0);
        check("drop_period_hold", period_a, 10);

`ifdef CLK_PERIOD_METER_DUTY_EN
        // 30% duty at period 10: |6-10| = 4 > 2*TOL.
        enable = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0);
        clear_logs();
        run_period(3, 7);
        run_period(3, 7);
        check("duty30_period", at(qa_period, 0), 10);
        check("duty30_high", at(qa_high, 0), 3);
        check("duty30_not_ok", at(qa_duty, 0), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at tick %0d", tick);
        $fatal(1, "watchdog");
    end

endmodule
